// File: rtl/modulo_pkg.sv
// Shared constants and the controller state type for the modulo datapath,
// ALU and controller.
package modulo_pkg;

    localparam int OP_W = 16;

    localparam logic [2:0] ALU_NOP = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;  // a - b
    localparam logic [2:0] ALU_LT  = 3'd2;  // bit 0 = signed(a) < signed(b)

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LOAD    = 4'd1,
        INIT    = 4'd2,
        CMP     = 4'd3,
        TERM_WB = 4'd4,
        CHECK   = 4'd5,
        SUB     = 4'd6,
        SUB_WB  = 4'd7,
        DONE    = 4'd8
    } ctrl_state_t;

endpackage

// File: rtl/wait_cnt_modulo.sv
// Loadable down-counter; o_tc is high when the count has reached zero.
module wait_cnt_modulo #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_ni,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/control_modulo.sv
// Controller sequencing datapath_modulo through Zahl1 mod Zahl2 by compare/subtract.
// Optional iteration limit enabled by defining MODULO_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | wait for start_i
// LOAD    | latch operands; operand error skips to DONE
// INIT    | ergebnis := Zahl1
// CMP     | ALU computes ergebnis < Zahl2 for ALU_LAT cycles
// TERM_WB | termination flag := ALU bit 0
// CHECK   | datapath reports valid when ergebnis < Zahl2
// SUB     | ALU computes ergebnis - Zahl2 for ALU_LAT cycles
// SUB_WB  | ergebnis := ALU result
// DONE    | one-cycle done_o (err_o on abort)
module control_modulo
    import modulo_pkg::*;
#(
    parameter int ALU_LAT = 2
`ifdef MODULO_TIMEOUT_EN
    ,
    parameter int MAX_ITER = 16'hFFFF
`endif
) (
    input  logic            clk,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [OP_W-1:0] zahl1_i,
    input  logic [OP_W-1:0] zahl2_i,
    input  logic            valid_i,
    output logic [2:0]      alu_mode_o,
    output logic            wren_update_zahlen_o,
    output logic            wren_zahl1_to_erg_o,
    output logic            wren_term_erg_o,
    output logic            wren_res_to_erg_o,
    output logic            erg_to_alu_a_o,
    output logic            zahl2_to_alu_b_o,
    output logic            check_for_termination_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    localparam logic [2:0] LAT_M1 = 3'(ALU_LAT - 1);

    ctrl_state_t r_state;
    ctrl_state_t w_state_nxt;
    logic        r_err;
    logic        w_op_err;
    logic        w_timeout;
    logic        w_cnt_load;
    logic        w_cnt_tc;
    logic        w_unused_zahl1;

    // only the sign of the dividend matters to the controller
    assign w_unused_zahl1 = &{1'b0, zahl1_i[OP_W-2:0]};
    assign w_op_err       = (zahl2_i == '0) | zahl1_i[OP_W-1] | zahl2_i[OP_W-1];
    assign w_cnt_load     = (r_state != CMP) && (r_state != SUB);

    wait_cnt_modulo #(
        .W(3)
    ) u_wait_cnt (
        .clk       (clk),
        .rst_ni    (rst_ni),
        .i_load    (w_cnt_load),
        .i_load_val(LAT_M1),
        .o_tc      (w_cnt_tc)
    );

`ifdef MODULO_TIMEOUT_EN
    localparam logic [15:0] MAX_ITER_W = 16'(MAX_ITER);
    logic [15:0] r_iter;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_iter <= '0;
        end else if (r_state == LOAD) begin
            r_iter <= '0;
        end else if (r_state == SUB_WB) begin
            r_iter <= r_iter + 16'd1;
        end
    end

    assign w_timeout = (r_state == SUB_WB) && ((r_iter + 16'd1) == MAX_ITER_W);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && start_i) begin
                r_err <= w_op_err;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start_i) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = r_err ? DONE : INIT;
            INIT:    w_state_nxt = CMP;
            CMP:     if (w_cnt_tc) w_state_nxt = TERM_WB;
            TERM_WB: w_state_nxt = CHECK;
            CHECK:   w_state_nxt = valid_i ? DONE : SUB;
            SUB:     if (w_cnt_tc) w_state_nxt = SUB_WB;
            SUB_WB:  w_state_nxt = w_timeout ? DONE : CMP;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_mode_o              = ALU_NOP;
        wren_update_zahlen_o    = 1'b0;
        wren_zahl1_to_erg_o     = 1'b0;
        wren_term_erg_o         = 1'b0;
        wren_res_to_erg_o       = 1'b0;
        erg_to_alu_a_o          = 1'b0;
        zahl2_to_alu_b_o        = 1'b0;
        check_for_termination_o = 1'b0;
        done_o                  = 1'b0;
        err_o                   = 1'b0;
        busy_o                  = (r_state != IDLE);
        case (r_state)
            LOAD:    wren_update_zahlen_o = 1'b1;
            INIT:    wren_zahl1_to_erg_o  = 1'b1;
            CMP: begin
                alu_mode_o       = ALU_LT;
                erg_to_alu_a_o   = 1'b1;
                zahl2_to_alu_b_o = 1'b1;
            end
            TERM_WB: wren_term_erg_o = 1'b1;
            CHECK:   check_for_termination_o = 1'b1;
            SUB: begin
                alu_mode_o       = ALU_SUB;
                erg_to_alu_a_o   = 1'b1;
                zahl2_to_alu_b_o = 1'b1;
            end
            SUB_WB:  wren_res_to_erg_o = 1'b1;
            DONE: begin
                done_o = 1'b1;
                err_o  = r_err;
            end
            default: ;
        endcase
    end

endmodule
